// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encodings and default width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor q = a - b, LSB first, with start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-2:0] r_q,      r_d;
    logic             br_q,     br_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] q_q,      q_d;
    logic             borrow_q, borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             a_msb_q,  a_msb_d;
    logic             b_msb_q,  b_msb_d;
    logic             ovf_q,    ovf_d;
`endif

    logic             bit_d;
    logic             bit_bout;
    logic [WIDTH-1:0] result_full;

    full_subtractor u_full_subtractor (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (br_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // Partial result holds the WIDTH-1 bits produced so far; the newest bit enters at the MSB.
    assign result_full = {bit_d, r_q};

    always_comb begin
        // NOTE: every variable gets a default here so no path through the case infers a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    r_d     = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = result_full[WIDTH-1:1];
                br_d  = bit_bout;
                cnt_d = cnt_q + CNT_W'(1);
                // Outputs load only on the final bit so partial results never leak.
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    q_d      = result_full;
                    borrow_d = bit_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ bit_d);
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the operand and result shift registers are ordinary flops, so they are reset like
    // the rest of the state; there is no RAM here that would justify leaving them unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            q_q      <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign q      = q_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4), with ovf checks when
// SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic             borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .q      (q),
        .borrow (borrow)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    // Issue one operation and wait (bounded) for its done pulse; inputs are scrambled after acceptance.
    task automatic run_op(input logic [3:0] ai, input logic [3:0] bi, output int bc,
                          output bit gd, output logic [3:0] qo, output logic bo,
                          output logic done_after);
        @(negedge clk);
        start = 1'b1; a = ai; b = bi;
        @(negedge clk);
        start = 1'b0; a = 4'($urandom); b = 4'($urandom);
        bc = 0; gd = 1'b0; qo = '0; bo = 1'b0; done_after = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                gd = 1'b1; qo = q; bo = borrow;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #2;
        n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (done !== 1'b0)   begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_vec++; if (q !== 4'h0)      begin n_err++; $display("FAIL reset_q: got %h expected 0", q); end
        n_vec++; if (borrow !== 1'b0) begin n_err++; $display("FAIL reset_borrow: got %b expected 0", borrow); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        n_vec++; if (ovf !== 1'b0)    begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero();
        int bc; bit gd; logic [3:0] qo; logic bo; logic da;
        run_op(4'h0, 4'h0, bc, gd, qo, bo, da);
        n_vec++; if (gd !== 1'b1) begin n_err++; $display("FAIL zero_done_seen: got %b expected 1 (timeout)", gd); end
        n_vec++; if (bc != 4)     begin n_err++; $display("FAIL zero_busy_cycles: got %0d expected 4", bc); end
        n_vec++; if (qo !== 4'h0) begin n_err++; $display("FAIL zero_q: got %h expected 0", qo); end
        n_vec++; if (bo !== 1'b0) begin n_err++; $display("FAIL zero_borrow: got %b expected 0", bo); end
        n_vec++; if (da !== 1'b0) begin n_err++; $display("FAIL zero_done_width: got %b expected 0", da); end
    endtask

    task automatic test_sequence();
        logic [3:0] va [4] = '{4'h1, 4'h1, 4'h2, 4'hf};
        logic [3:0] vb [4] = '{4'h0, 4'h1, 4'h1, 4'hf};
        logic [3:0] vq [4] = '{4'h1, 4'h0, 4'h1, 4'h0};
        int bc; bit gd; logic [3:0] qo; logic bo; logic da;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], bc, gd, qo, bo, da);
            n_vec++; if (gd !== 1'b1)  begin n_err++; $display("FAIL seq%0d_done_seen: got %b expected 1", i, gd); end
            n_vec++; if (bc != 4)      begin n_err++; $display("FAIL seq%0d_busy_cycles: got %0d expected 4", i, bc); end
            n_vec++; if (qo !== vq[i]) begin n_err++; $display("FAIL seq%0d_q: got %h expected %h", i, qo, vq[i]); end
            n_vec++; if (bo !== 1'b0)  begin n_err++; $display("FAIL seq%0d_borrow: got %b expected 0", i, bo); end
        end
    endtask

    task automatic test_borrow();
        int bc; bit gd; logic [3:0] qo; logic bo; logic da;
        run_op(4'h0, 4'h1, bc, gd, qo, bo, da);
        n_vec++; if (qo !== 4'hf) begin n_err++; $display("FAIL borrow_0m1_q: got %h expected f", qo); end
        n_vec++; if (bo !== 1'b1) begin n_err++; $display("FAIL borrow_0m1_borrow: got %b expected 1", bo); end
        run_op(4'h3, 4'h5, bc, gd, qo, bo, da);
        n_vec++; if (qo !== 4'he) begin n_err++; $display("FAIL borrow_3m5_q: got %h expected e", qo); end
        n_vec++; if (bo !== 1'b1) begin n_err++; $display("FAIL borrow_3m5_borrow: got %b expected 1", bo); end
        n_vec++; if (q !== 4'he)  begin n_err++; $display("FAIL borrow_q_hold_idle: got %h expected e", q); end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        logic [3:0] qo = '0;
        @(negedge clk);
        start = 1'b1; a = 4'h9; b = 4'h2;
        @(negedge clk);
        start = 1'b1; a = 4'h0; b = 4'h0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin dones++; qo = q; end
            @(negedge clk);
        end
        n_vec++; if (dones != 1)  begin n_err++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
        n_vec++; if (qo !== 4'h7) begin n_err++; $display("FAIL ignore_q: got %h expected 7", qo); end
        n_vec++; if (borrow !== 1'b0) begin n_err++; $display("FAIL ignore_borrow: got %b expected 0", borrow); end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        int bc; bit gd; logic [3:0] qo; logic bo; logic da;
        @(negedge clk);
        start = 1'b1; a = 4'h6; b = 4'h3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_vec++; if (done !== 1'b0)   begin n_err++; $display("FAIL abort_done: got %b expected 0", done); end
        n_vec++; if (q !== 4'h0)      begin n_err++; $display("FAIL abort_q: got %h expected 0", q); end
        n_vec++; if (borrow !== 1'b0) begin n_err++; $display("FAIL abort_borrow: got %b expected 0", borrow); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        n_vec++; if (dones != 0) begin n_err++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
        run_op(4'h6, 4'h3, bc, gd, qo, bo, da);
        n_vec++; if (qo !== 4'h3) begin n_err++; $display("FAIL abort_rerun_q: got %h expected 3", qo); end
        n_vec++; if (bo !== 1'b0) begin n_err++; $display("FAIL abort_rerun_borrow: got %b expected 0", bo); end
    endtask

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    task automatic test_ovf();
        int bc; bit gd; logic [3:0] qo; logic bo; logic da;
        run_op(4'h8, 4'h1, bc, gd, qo, bo, da);
        n_vec++; if (qo !== 4'h7)  begin n_err++; $display("FAIL ovf_8m1_q: got %h expected 7", qo); end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_8m1_ovf: got %b expected 1", ovf); end
        run_op(4'h5, 4'h2, bc, gd, qo, bo, da);
        n_vec++; if (qo !== 4'h3)  begin n_err++; $display("FAIL ovf_5m2_q: got %h expected 3", qo); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_5m2_ovf: got %b expected 0", ovf); end
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_sequence();
        test_borrow();
        test_ignore_start();
        test_reset_abort();
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
